svn_scan_rx: RTL and testbench
==============================

Name: svn_scan_rx

Overview:
- Receive-side counterpart of the team's seven-segment display driver.
- Observes a multiplexed display bus: segment lines CA..CG and DP, plus the scanning anode vector AN.
- Decodes each lit digit's segment pattern back to a 4-bit hex value and checks scan order.
- Publishes a complete, atomically updated frame of N_DIGITS nibbles for self-check, loopback and display-mirroring logic.

Parameters:
- N_DIGITS, 8: anodes on the bus; legal range 2..8.
- SETTLE, 1: consecutive cycles an anode value must hold before its digit is captured; legal range >= 1.

Ports:
- clk  input  1  system clock; all bus inputs are synchronous to it.
- sys_rst_n  input  1  reset, asynchronous and active-low.
- CA, CB, CC, CD, CE, CF, CG  input  1 each  segment lines, active-low.
- DP  input  1  decimal point, active-low.
- AN  input  N_DIGITS  anode enables, active-low; a legal value is one-hot-low.
- frame_data  output  4*N_DIGITS  decoded nibbles; digit i is at bits [4i+3:4i].
- frame_dp  output  N_DIGITS  DP state per digit, 1 = lit.
- frame_ok  output  1  every digit in the last published frame was a legal pattern.
- frame_valid  output  1  one-cycle pulse when frame_data, frame_dp and frame_ok update.
- seq_err  output  1  one-cycle pulse on an out-of-order digit.
- locked  output  1  level; high while in TRACK state.

Behaviour:
- Reset, asynchronous on sys_rst_n low:
  - all outputs 0; input registers 0; SETTLE counter 0; shadow frame 0; state IDLE.
  - Reset mid-frame discards the partial frame; no frame_valid is emitted for it.
- Input stage:
  - One register stage on {CA..CG, DP, AN}.
  - All decisions use the registered values: an_q, seg_q, dp_q.
- Dwell detection:
  - The counter increments while an_q equals its previous value and is one-hot-low.
  - It clears on any change, on all-ones, or on multi-hot.
  - Capture fires exactly once per dwell, on the SETTLE-th consecutive qualifying cycle.
  - Non-one-hot AN values are ignored; no error is flagged.
- Decode (active-low pattern {CA..CG}, CA as MSB):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
  - Any other pattern is illegal: nibble = 0 and the digit's legal bit = 0.
- Capture:
  - Write nibble, ~dp_q and the legal bit for index i (the position of the zero in an_q) into the shadow frame.
- Scan order: the active zero advances from bit 0 upward and wraps from N_DIGITS-1 to 0.
- State machine (IDLE, TRACK):
  - IDLE: a capture of digit 0 clears the shadow legal bits, stores digit 0, sets expected = 1, and goes to TRACK. Captures of other digits are ignored silently.
  - TRACK, capture of index == expected: store it, expected++.
  - TRACK, capture of the last digit (index N_DIGITS-1 == expected): next cycle frame_valid = 1, the shadow is copied to the outputs, frame_ok = AND of the legal bits, expected = 0. The state stays TRACK.
  - TRACK, capture of index != expected: seq_err pulses the next cycle and the shadow is discarded. If the offending index is 0 it is taken as a new start (store it, expected = 1, remain TRACK); otherwise go to IDLE.
- Latency: bus change to capture is 1 + SETTLE cycles; last capture to frame_valid is 1 cycle.
- With SETTLE = 1 and the anode advancing every clock, one frame is published every N_DIGITS cycles.
- frame_data, frame_dp and frame_ok hold between frame_valid pulses.

Decomposition:
- Shared package:
  - the 16 segment-pattern constants (the same table the display decoder uses);
  - the state enum {IDLE, TRACK};
  - the DIGIT_W = 4 constant.
- One sub-module, svn_pattern_decode: combinational map from a 7-bit pattern to {legal, nibble[3:0]}. It is reused by the display self-check.
- Dwell, order tracking and the frame registers stay in svn_scan_rx.

Test Plan:
- Reset release, then drive the anode sequence FE, FD, FB, F7, EF, DF, BF, 7F (one per clock, SETTLE=1) with digits 0..7 and DP lit on digit 3:
  - frame_valid pulses one cycle after the 7F dwell;
  - frame_data = 32'h76543210, frame_dp = 8'h08, frame_ok = 1, locked = 1.
- Same sweep with digit 5's pattern set to 1111111 -> frame_ok = 0 and nibble 5 = 0; the other nibbles are correct.
- Sequence FE, FD, F7 -> seq_err pulses one cycle after the F7 capture, locked falls, and no frame_valid is produced. A following full sweep from FE publishes normally.
- SETTLE=3; FE held for 2 cycles, then FD -> no capture, state remains IDLE. FE held for 5 cycles -> exactly one capture.
- AN = 8'hFC (multi-hot) or 8'hFF inserted between digits -> ignored with no error; the dwell restarts on the next one-hot value.
- Assert sys_rst_n low after digit 4 of a sweep -> all outputs go 0 immediately. After release, a full sweep publishes 32'h76543210 with no stale digits.

Source files
------------

// File: rtl/svn_scan_rx_pkg.sv
// Shared definitions for the seven-segment scan receiver.
// Segment table matches the display driver (active-low, CA as MSB).
package svn_scan_rx_pkg;

    localparam int DIGIT_W = 4;
    localparam int SEG_W   = 7;

    localparam logic [SEG_W-1:0] SEG_0 = 7'b0000001;
    localparam logic [SEG_W-1:0] SEG_1 = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_2 = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_3 = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_4 = 7'b1001100;
    localparam logic [SEG_W-1:0] SEG_5 = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_6 = 7'b0100000;
    localparam logic [SEG_W-1:0] SEG_7 = 7'b0001111;
    localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9 = 7'b0000100;
    localparam logic [SEG_W-1:0] SEG_A = 7'b0001000;
    localparam logic [SEG_W-1:0] SEG_B = 7'b1100000;
    localparam logic [SEG_W-1:0] SEG_C = 7'b0110001;
    localparam logic [SEG_W-1:0] SEG_D = 7'b1000010;
    localparam logic [SEG_W-1:0] SEG_E = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_F = 7'b0111000;

    // Index n holds the pattern for hex digit n.
    localparam logic [15:0][SEG_W-1:0] SEG_TAB = {
        SEG_F, SEG_E, SEG_D, SEG_C,
        SEG_B, SEG_A, SEG_9, SEG_8,
        SEG_7, SEG_6, SEG_5, SEG_4,
        SEG_3, SEG_2, SEG_1, SEG_0
    };

    typedef enum logic {
        IDLE,
        TRACK
    } state_t;

endpackage

// File: rtl/svn_pattern_decode.sv
// Maps a 7-bit active-low segment pattern back to its hex nibble.
// Unknown patterns give nibble 0 with legal low.
module svn_pattern_decode
    import svn_scan_rx_pkg::*;
(
    input  logic [SEG_W-1:0]   pattern,
    output logic               legal,
    output logic [DIGIT_W-1:0] nibble
);

    // Table lookup; at most one entry can match.
    always_comb begin
        legal  = 1'b0;
        nibble = '0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == SEG_TAB[i]) begin
                legal  = 1'b1;
                nibble = DIGIT_W'(i);
            end
        end
    end

endmodule

// File: rtl/svn_scan_rx.sv
// Scan receiver: samples a multiplexed seven-segment bus, decodes each
// settled digit and publishes whole frames when the scan order holds.
module svn_scan_rx
    import svn_scan_rx_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int SETTLE   = 1
) (
    input  logic                          clk,
    input  logic                          sys_rst_n,
    input  logic                          CA,
    input  logic                          CB,
    input  logic                          CC,
    input  logic                          CD,
    input  logic                          CE,
    input  logic                          CF,
    input  logic                          CG,
    input  logic                          DP,
    input  logic [N_DIGITS-1:0]           AN,
    output logic [DIGIT_W*N_DIGITS-1:0]   frame_data,
    output logic [N_DIGITS-1:0]           frame_dp,
    output logic                          frame_ok,
    output logic                          frame_valid,
    output logic                          seq_err,
    output logic                          locked
);

    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CW = $clog2(SETTLE + 2);

    logic [N_DIGITS-1:0]         an_q;
    logic [N_DIGITS-1:0]         an_prev;
    logic [SEG_W-1:0]            seg_q;
    logic                        dp_q;
    logic [CW-1:0]               cnt;
    logic [CW-1:0]               run;
    logic [N_DIGITS-1:0]         act;
    logic                        one_hot;
    logic                        capture;
    logic [IW-1:0]               idx;
    logic                        legal;
    logic [DIGIT_W-1:0]          nib;

    state_t                      state;
    state_t                      state_d;
    logic [IW-1:0]               exp_idx;
    logic [IW-1:0]               exp_d;
    logic [DIGIT_W*N_DIGITS-1:0] sh_data;
    logic [DIGIT_W*N_DIGITS-1:0] sh_data_d;
    logic [N_DIGITS-1:0]         sh_dp;
    logic [N_DIGITS-1:0]         sh_dp_d;
    logic [N_DIGITS-1:0]         sh_legal;
    logic [N_DIGITS-1:0]         sh_legal_d;
    logic                        clr;
    logic                        st;
    logic                        pub;
    logic                        err;

    // Register the bus once; every decision below uses these copies.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            an_q    <= '0;
            an_prev <= '0;
            seg_q   <= '0;
            dp_q    <= 1'b0;
        end else begin
            an_q    <= AN;
            an_prev <= an_q;
            seg_q   <= {CA, CB, CC, CD, CE, CF, CG};
            dp_q    <= DP;
        end
    end

    // One-hot-low check, digit index and dwell run length.
    always_comb begin
        act     = ~an_q;
        one_hot = (act != '0) &&
                  ((act & (act - N_DIGITS'(1))) == '0);
        idx     = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!an_q[i]) idx = IW'(i);
        end
        run = '0;
        if (one_hot) run = (an_q == an_prev) ? cnt + CW'(1) : CW'(1);
        capture = one_hot && (run == CW'(SETTLE));
    end

    // Dwell counter saturates at SETTLE so a long dwell captures once.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt <= '0;
        end else if (!one_hot) begin
            cnt <= '0;
        end else if (run <= CW'(SETTLE)) begin
            cnt <= run;
        end
    end

    svn_pattern_decode u_dec (
        .pattern (seg_q),
        .legal   (legal),
        .nibble  (nib)
    );

    // Order tracking: decides store / clear / publish / error per capture.
    always_comb begin
        state_d    = state;
        exp_d      = exp_idx;
        clr        = 1'b0;
        st         = 1'b0;
        pub        = 1'b0;
        err        = 1'b0;
        if (capture) begin
            unique case (state)
                IDLE: begin
                    if (idx == '0) begin
                        clr     = 1'b1;
                        st      = 1'b1;
                        exp_d   = IW'(1);
                        state_d = TRACK;
                    end
                end
                TRACK: begin
                    if (idx == exp_idx) begin
                        st = 1'b1;
                        if (idx == IW'(N_DIGITS - 1)) begin
                            pub   = 1'b1;
                            exp_d = '0;
                        end else begin
                            exp_d = exp_idx + IW'(1);
                        end
                    end else begin
                        err = 1'b1;
                        clr = 1'b1;
                        if (idx == '0) begin
                            st    = 1'b1;
                            exp_d = IW'(1);
                        end else begin
                            exp_d   = '0;
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        sh_data_d  = sh_data;
        sh_dp_d    = sh_dp;
        sh_legal_d = sh_legal;
        if (clr) begin
            sh_data_d  = '0;
            sh_dp_d    = '0;
            sh_legal_d = '0;
        end
        if (st) begin
            sh_data_d[DIGIT_W*idx +: DIGIT_W] = nib;
            sh_dp_d[idx]                      = ~dp_q;
            sh_legal_d[idx]                   = legal;
        end
    end

    // State, shadow frame and the atomically published outputs.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            exp_idx     <= '0;
            sh_data     <= '0;
            sh_dp       <= '0;
            sh_legal    <= '0;
            frame_data  <= '0;
            frame_dp    <= '0;
            frame_ok    <= 1'b0;
            frame_valid <= 1'b0;
            seq_err     <= 1'b0;
        end else begin
            state       <= state_d;
            exp_idx     <= exp_d;
            sh_data     <= sh_data_d;
            sh_dp       <= sh_dp_d;
            sh_legal    <= sh_legal_d;
            frame_valid <= pub;
            seq_err     <= err;
            if (pub) begin
                frame_data <= sh_data_d;
                frame_dp   <= sh_dp_d;
                frame_ok   <= &sh_legal_d;
            end
        end
    end

    assign locked = (state == TRACK);

endmodule

// File: tb/tb_svn_scan_rx.sv
// Directed bench for svn_scan_rx: one DUT at SETTLE=1, one at SETTLE=3,
// both fed from the same bus.
module tb_svn_scan_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg;
    logic        dp_n;
    logic [7:0]  an;

    logic [31:0] fd1, fd3;
    logic [7:0]  fdp1, fdp3;
    logic        ok1, ok3, fv1, fv3, se1, se3, lk1, lk3;

    int n_chk = 0;
    int n_fail = 0;
    int fv_cnt1 = 0;
    int se_cnt1 = 0;
    int se_cnt3 = 0;

    always #5 clk = ~clk;

    svn_scan_rx #(.N_DIGITS(8), .SETTLE(1)) dut1 (
        .clk(clk), .sys_rst_n(rst_n),
        .CA(seg[6]), .CB(seg[5]), .CC(seg[4]), .CD(seg[3]),
        .CE(seg[2]), .CF(seg[1]), .CG(seg[0]), .DP(dp_n), .AN(an),
        .frame_data(fd1), .frame_dp(fdp1), .frame_ok(ok1),
        .frame_valid(fv1), .seq_err(se1), .locked(lk1)
    );

    svn_scan_rx #(.N_DIGITS(8), .SETTLE(3)) dut3 (
        .clk(clk), .sys_rst_n(rst_n),
        .CA(seg[6]), .CB(seg[5]), .CC(seg[4]), .CD(seg[3]),
        .CE(seg[2]), .CF(seg[1]), .CG(seg[0]), .DP(dp_n), .AN(an),
        .frame_data(fd3), .frame_dp(fdp3), .frame_ok(ok3),
        .frame_valid(fv3), .seq_err(se3), .locked(lk3)
    );

    // Pulse counters.
    always @(posedge clk) begin
        if (fv1) fv_cnt1 <= fv_cnt1 + 1;
        if (se1) se_cnt1 <= se_cnt1 + 1;
        if (se3) se_cnt3 <= se_cnt3 + 1;
    end

    function automatic logic [6:0] pat(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    task automatic drive(input logic [7:0] a, input logic [6:0] p,
                         input logic lit, input int cyc);
        an   = a;
        seg  = p;
        dp_n = ~lit;
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    task automatic sweep(input logic [31:0] nib, input logic [7:0] dpm,
                         input int bad, input int hold);
        logic [7:0] a;
        for (int i = 0; i < 8; i++) begin
            a = ~(8'h01 << i);
            drive(a, (i == bad) ? 7'h7F : pat(nib[4*i +: 4]), dpm[i], hold);
        end
        drive(8'hFF, 7'h7F, 1'b0, 1);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        an = 8'hFF; seg = 7'h7F; dp_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if ({fd1, fdp1, ok1, fv1, se1, lk1} !== 44'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got %h expected 0",
                     {fd1, fdp1, ok1, fv1, se1, lk1});
        end
        rst_n = 1'b1;
        drive(8'hFF, 7'h7F, 1'b0, 2);
        n_chk++;
        if (lk1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_locked got %b expected 0", lk1);
        end
    endtask

    task automatic test_basic_frame;
        sweep(32'h76543210, 8'h08, -1, 1);
        n_chk++;
        if (fv1 !== 1'b1) begin
            n_fail++; $display("FAIL basic_valid got %b expected 1", fv1);
        end
        n_chk++;
        if (fd1 !== 32'h76543210) begin
            n_fail++; $display("FAIL basic_data got %h expected 76543210", fd1);
        end
        n_chk++;
        if (fdp1 !== 8'h08) begin
            n_fail++; $display("FAIL basic_dp got %h expected 08", fdp1);
        end
        n_chk++;
        if (ok1 !== 1'b1) begin
            n_fail++; $display("FAIL basic_ok got %b expected 1", ok1);
        end
        n_chk++;
        if (lk1 !== 1'b1) begin
            n_fail++; $display("FAIL basic_locked got %b expected 1", lk1);
        end
        drive(8'hFF, 7'h7F, 1'b0, 1);
        n_chk++;
        if (fv1 !== 1'b0 || fd1 !== 32'h76543210) begin
            n_fail++;
            $display("FAIL basic_hold got fv=%b data=%h expected 0/76543210",
                     fv1, fd1);
        end
    endtask

    task automatic test_illegal;
        sweep(32'h76543210, 8'h00, 5, 1);
        n_chk++;
        if (fv1 !== 1'b1 || ok1 !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_ok got fv=%b ok=%b expected 1/0", fv1, ok1);
        end
        n_chk++;
        if (fd1 !== 32'h76043210 || fdp1 !== 8'h00) begin
            n_fail++;
            $display("FAIL illegal_data got %h/%h expected 76043210/00",
                     fd1, fdp1);
        end
    endtask

    task automatic test_seq_err;
        int fv0, se0;
        drive(8'hFF, 7'h7F, 1'b0, 2);
        fv0 = fv_cnt1;
        se0 = se_cnt1;
        drive(8'hFE, pat(4'h0), 1'b0, 1);
        drive(8'hFD, pat(4'h1), 1'b0, 1);
        drive(8'hF7, pat(4'h3), 1'b0, 1);
        drive(8'hFF, 7'h7F, 1'b0, 1);
        n_chk++;
        if (se1 !== 1'b1 || lk1 !== 1'b0) begin
            n_fail++;
            $display("FAIL seq_err_pulse got se=%b lk=%b expected 1/0",
                     se1, lk1);
        end
        drive(8'hFF, 7'h7F, 1'b0, 2);
        n_chk++;
        if (fv_cnt1 != fv0 || se_cnt1 != se0 + 1) begin
            n_fail++;
            $display("FAIL seq_err_counts got fv=%0d se=%0d expected %0d/%0d",
                     fv_cnt1 - fv0, se_cnt1 - se0, 0, 1);
        end
        sweep(32'hA9876543, 8'h81, -1, 1);
        n_chk++;
        if (fv1 !== 1'b1 || fd1 !== 32'hA9876543 || fdp1 !== 8'h81 ||
            ok1 !== 1'b1) begin
            n_fail++;
            $display("FAIL seq_err_recover got fv=%b data=%h dp=%h ok=%b expected 1/a9876543/81/1",
                     fv1, fd1, fdp1, ok1);
        end
    endtask

    task automatic test_multihot;
        logic [31:0] nib;
        logic [7:0]  a;
        int          se0;
        nib = 32'hFEDCBA98;
        se0 = se_cnt1;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) drive(8'hFC, pat(4'h1), 1'b0, 1);
            if (i == 6) drive(8'hFF, pat(4'h2), 1'b0, 1);
            a = ~(8'h01 << i);
            drive(a, pat(nib[4*i +: 4]), 1'b0, 1);
        end
        drive(8'hFF, 7'h7F, 1'b0, 1);
        n_chk++;
        if (fv1 !== 1'b1 || fd1 !== 32'hFEDCBA98 || ok1 !== 1'b1) begin
            n_fail++;
            $display("FAIL multihot_frame got fv=%b data=%h ok=%b expected 1/fedcba98/1",
                     fv1, fd1, ok1);
        end
        n_chk++;
        if (se_cnt1 != se0 || se1 !== 1'b0 || lk1 !== 1'b1) begin
            n_fail++;
            $display("FAIL multihot_noerr got errs=%0d lk=%b expected 0/1",
                     se_cnt1 - se0, lk1);
        end
    endtask

    task automatic test_mid_reset;
        logic [7:0] a;
        int fv0;
        for (int i = 0; i < 5; i++) begin
            a = ~(8'h01 << i);
            drive(a, pat(4'h9), 1'b1, 1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({fd1, fdp1, ok1, fv1, se1, lk1} !== 44'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs got %h expected 0",
                     {fd1, fdp1, ok1, fv1, se1, lk1});
        end
        drive(8'hFF, 7'h7F, 1'b0, 1);
        rst_n = 1'b1;
        drive(8'hFF, 7'h7F, 1'b0, 2);
        fv0 = fv_cnt1;
        n_chk++;
        if (fv0 != 0 && fv1 !== 1'b0) begin
            n_fail++; $display("FAIL midreset_nopulse got %b expected 0", fv1);
        end
        sweep(32'h76543210, 8'h00, -1, 1);
        n_chk++;
        if (fv1 !== 1'b1 || fd1 !== 32'h76543210 || fdp1 !== 8'h00 ||
            ok1 !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_frame got fv=%b data=%h dp=%h ok=%b expected 1/76543210/00/1",
                     fv1, fd1, fdp1, ok1);
        end
        drive(8'hFF, 7'h7F, 1'b0, 1);
        n_chk++;
        if (fv_cnt1 != fv0 + 1) begin
            n_fail++;
            $display("FAIL midreset_count got %0d expected 1", fv_cnt1 - fv0);
        end
    endtask

    task automatic test_settle;
        logic [7:0] a;
        int se0;
        rst_n = 1'b0;
        drive(8'hFF, 7'h7F, 1'b0, 1);
        rst_n = 1'b1;
        drive(8'hFF, 7'h7F, 1'b0, 2);
        drive(8'hFE, pat(4'h0), 1'b0, 2);
        drive(8'hFD, pat(4'h1), 1'b0, 1);
        drive(8'hFF, 7'h7F, 1'b0, 3);
        n_chk++;
        if (lk3 !== 1'b0) begin
            n_fail++; $display("FAIL settle_short got lk=%b expected 0", lk3);
        end
        se0 = se_cnt3;
        drive(8'hFE, pat(4'h0), 1'b0, 5);
        n_chk++;
        if (lk3 !== 1'b1) begin
            n_fail++; $display("FAIL settle_lock got lk=%b expected 1", lk3);
        end
        for (int i = 1; i < 8; i++) begin
            a = ~(8'h01 << i);
            drive(a, pat(4'(i)), 1'b0, 3);
        end
        drive(8'hFF, 7'h7F, 1'b0, 1);
        n_chk++;
        if (fv3 !== 1'b1 || fd3 !== 32'h76543210 || ok3 !== 1'b1) begin
            n_fail++;
            $display("FAIL settle_frame got fv=%b data=%h ok=%b expected 1/76543210/1",
                     fv3, fd3, ok3);
        end
        drive(8'hFF, 7'h7F, 1'b0, 1);
        n_chk++;
        if (se_cnt3 != se0) begin
            n_fail++;
            $display("FAIL settle_once got errs=%0d expected 0", se_cnt3 - se0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic_frame();
        test_illegal();
        test_seq_err();
        test_multihot();
        test_mid_reset();
        test_settle();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
